hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Stall/flush generator for the 5-stage pipeline; the counterpart of the forwarding unit.
- Covers the cases forwarding cannot resolve:
  - load-use hazards
  - reads of HI/LO, or a new multiply, while the multi-cycle multiplier is busy
  - taken-branch squash
- Sits beside the ID stage; drives PC/IF-ID hold, ID/EX bubble insertion and IF-ID flush.

Parameters:
- LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..3).
- MULT_LAT, 4, cycles the multiplier stays busy after MultStart (2..15).

Ports:
- Clock  input  1  pipeline clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ID_Instruction  input  32  instruction currently in the ID stage.
- ID_Valid  input  1  ID stage holds a real (non-bubble) instruction.
- EX_MemRead  input  1  instruction in EX is a load.
- EX_RegWrite  input  1  instruction in EX writes the register file.
- EX_RegDest  input  5  destination register of the instruction in EX.
- MultStart  input  1  one-cycle pulse: mult/multu entered EX this cycle.
- BranchTaken  input  1  branch resolved taken this cycle.
- Stall  output  1  hold PC and IF/ID.
- IDEXBubble  output  1  load NOP control into ID/EX.
- IFIDFlush  output  1  squash IF/ID contents.
- MultBusy  output  1  multiplier result not yet valid.

Behaviour:
- Reset:
  - Reset low forces state IDLE and clears both counters immediately, asynchronously.
  - While Reset is low, all outputs are 0.
- Source decode:
  - rs = ID_Instruction[25:21]; rs always counts as a source.
  - rt = ID_Instruction[20:16]; rt counts as a source only for opcodes 0x00, 0x04, 0x05, 0x28, 0x29, 0x2B.
  - Register 0 never matches.
- LoadHit = ID_Valid & EX_MemRead & EX_RegWrite & (EX_RegDest != 0) & (EX_RegDest == rs, or EX_RegDest == rt when rt is a source).
- MultHit = ID_Valid & MultBusy & (opcode 0x00) & (funct is 0x10, 0x12, 0x18 or 0x19).
- States: IDLE, LOAD_STALL, FLUSH. The multiplier busy counter mcnt runs independently of state.
- IDLE:
  - LoadHit: Stall=1 and IDEXBubble=1 this cycle (combinational).
  - If LOAD_LAT>1, go to LOAD_STALL with lcnt = LOAD_LAT-1.
- LOAD_STALL:
  - Stall=1 and IDEXBubble=1; lcnt decrements each cycle.
  - Go to IDLE in the cycle lcnt reaches 1.
- MultHit: Stall=1 and IDEXBubble=1 in any state; no state change.
- mcnt:
  - MultStart loads mcnt = MULT_LAT; otherwise mcnt decrements while nonzero.
  - MultBusy = (mcnt != 0).
  - MultStart while mcnt is already nonzero reloads MULT_LAT. The upstream stall on funct 0x18/0x19 normally prevents this.
- BranchTaken has highest priority:
  - IFIDFlush=1, Stall=0 and IDEXBubble=0 that cycle; LoadHit and MultHit are ignored.
  - State goes to FLUSH, and any LOAD_STALL is abandoned with lcnt cleared.
- FLUSH lasts exactly one cycle:
  - IFIDFlush=0.
  - Stall/bubble may assert from a new LoadHit or MultHit.
  - Return to IDLE, or enter LOAD_STALL as from IDLE.
- BranchTaken does not disturb mcnt; the multiply already in flight completes.
- All outputs are combinational from state, counters and current inputs. There is no output register and no added latency.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- With the macro defined:
  - Extra output StallCount [31:0] counts cycles with Stall=1.
  - Saturates at 0xFFFFFFFF; cleared by Reset.
- Without the macro: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - state enum {IDLE, LOAD_STALL, FLUSH}
  - opcode constants OP_RTYPE=0x00, OP_BEQ=0x04, OP_BNE=0x05, OP_SB=0x28, OP_SH=0x29, OP_SW=0x2B
  - funct constants F_MFHI=0x10, F_MFLO=0x12, F_MULT=0x18, F_MULTU=0x19
- One sub-module, hazard_src_decode:
  - input: instruction
  - outputs: rs, rt, rt_used, is_hilo_or_mult
- The FSM, counters and priority logic stay in hazard_stall_unit.

Test Plan:
- Load-use: EX lw to $8 (EX_MemRead=1, EX_RegWrite=1, EX_RegDest=8); ID add $3,$8,$9 -> Stall=1 and IDEXBubble=1 for exactly 1 cycle (LOAD_LAT=1), then 0.
- rt-not-source: EX lw to $8; ID addi $8,$8... is rs-hit (stalls). ID lui with rt=8, rs=0 -> no stall. ID sw with rt=8 -> stall.
- $zero: EX lw with EX_RegDest=0; ID add $3,$0,$0 -> Stall=0.
- Multiply:
  - MultStart pulse, then mflo in ID on each of the next 4 cycles -> Stall=1 for 4 cycles, MultBusy=1 for 4 cycles.
  - On cycle 5: Stall=0, MultBusy=0.
- Branch priority: LoadHit and BranchTaken in the same cycle -> IFIDFlush=1, Stall=0. Next cycle IFIDFlush=0.
  - With LOAD_LAT=3, BranchTaken mid-stall -> stall ends immediately.
- Reset mid-operation: Reset low during LOAD_STALL with mcnt=2 -> all outputs 0 immediately (before the next edge). After release: state IDLE, MultBusy=0. With HAZARD_STATS_EN: StallCount=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and instruction-field constants for the hazard stall unit.
// The optional stall statistics counter is enabled with HAZARD_STATS_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX-side signal bundle between the pipeline (master) and the hazard
// stall unit (slave). StallCount exists only when HAZARD_STATS_EN is defined.
interface hazard_stall_unit_if;

    logic [31:0] ID_Instruction;
    logic        ID_Valid;
    logic        EX_MemRead;
    logic        EX_RegWrite;
    logic [4:0]  EX_RegDest;
    logic        MultStart;
    logic        BranchTaken;
    logic        Stall;
    logic        IDEXBubble;
    logic        IFIDFlush;
    logic        MultBusy;
`ifdef HAZARD_STATS_EN
    logic [31:0] StallCount;

    modport master (
        output ID_Instruction, ID_Valid, EX_MemRead, EX_RegWrite, EX_RegDest,
               MultStart, BranchTaken,
        input  Stall, IDEXBubble, IFIDFlush, MultBusy, StallCount
    );

    modport slave (
        input  ID_Instruction, ID_Valid, EX_MemRead, EX_RegWrite, EX_RegDest,
               MultStart, BranchTaken,
        output Stall, IDEXBubble, IFIDFlush, MultBusy, StallCount
    );
`else
    modport master (
        output ID_Instruction, ID_Valid, EX_MemRead, EX_RegWrite, EX_RegDest,
               MultStart, BranchTaken,
        input  Stall, IDEXBubble, IFIDFlush, MultBusy
    );

    modport slave (
        input  ID_Instruction, ID_Valid, EX_MemRead, EX_RegWrite, EX_RegDest,
               MultStart, BranchTaken,
        output Stall, IDEXBubble, IFIDFlush, MultBusy
    );
`endif

endinterface

// File: rtl/hazard_src_decode.sv
// Extracts the source registers of the ID-stage instruction and flags
// instructions that depend on the multiplier (mfhi/mflo/mult/multu).
module hazard_src_decode (
    input  logic [31:0] instruction,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        rt_used,
    output logic        is_hilo_or_mult
);
    import hazard_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instruction[31:26];
    assign funct         = instruction[5:0];
    assign rs            = instruction[25:21];
    assign rt            = instruction[20:16];
    assign unused_fields = ^instruction[15:6];

    // rt is a real source only for R-type, branches that compare two regs, and stores
    always_comb begin
        rt_used = opcode inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW};
    end

    // HI/LO reads and new multiplies must wait for the multiplier
    always_comb begin
        is_hilo_or_mult = (opcode == OP_RTYPE) &&
                          (funct inside {F_MFHI, F_MFLO, F_MULT, F_MULTU});
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush generator beside the ID stage: load-use stalls, multiplier-busy
// stalls and taken-branch squash. All outputs are combinational.
// Optional StallCount statistics port: define HAZARD_STATS_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no hazard in progress; a load-use hit stalls this cycle
// LOAD_STALL | extra load-use stall cycles (LOAD_LAT > 1), lcnt remaining
// FLUSH      | one cycle after a taken branch; behaves like IDLE otherwise
module hazard_stall_unit #(
    parameter int LOAD_LAT = 1,
    parameter int MULT_LAT = 4
) (
    input logic            Clock,
    input logic            Reset,
    hazard_stall_unit_if.slave hz
);
    import hazard_pkg::*;

    localparam logic [1:0] LCNT_INIT = 2'(LOAD_LAT - 1);
    localparam logic [3:0] MCNT_INIT = 4'(MULT_LAT);

    state_t     state;
    state_t     state_next;
    logic [1:0] lcnt;
    logic [1:0] lcnt_next;
    logic [3:0] mcnt;

    logic [4:0] rs;
    logic [4:0] rt;
    logic       rt_used;
    logic       is_hilo_or_mult;
    logic       load_hit;
    logic       mult_busy;
    logic       mult_hit;
    logic       stall;
    logic       flush;

    hazard_src_decode u_decode (
        .instruction     (hz.ID_Instruction),
        .rs              (rs),
        .rt              (rt),
        .rt_used         (rt_used),
        .is_hilo_or_mult (is_hilo_or_mult)
    );

    assign load_hit  = hz.ID_Valid && hz.EX_MemRead && hz.EX_RegWrite &&
                       (hz.EX_RegDest != 5'd0) &&
                       ((hz.EX_RegDest == rs) || (rt_used && (hz.EX_RegDest == rt)));
    assign mult_busy = (mcnt != 4'd0);
    assign mult_hit  = hz.ID_Valid && mult_busy && is_hilo_or_mult;

    // State register and load-stall counter
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            lcnt  <= 2'd0;
        end else begin
            state <= state_next;
            lcnt  <= lcnt_next;
        end
    end

    // Next state and stall/flush decisions; a taken branch overrides everything
    always_comb begin
        state_next = state;
        lcnt_next  = lcnt;
        stall      = 1'b0;
        flush      = 1'b0;
        if (hz.BranchTaken) begin
            flush      = 1'b1;
            state_next = FLUSH;
            lcnt_next  = 2'd0;
        end else begin
            case (state)
                LOAD_STALL: begin
                    stall = 1'b1;
                    if (lcnt <= 2'd1) begin
                        state_next = IDLE;
                        lcnt_next  = 2'd0;
                    end else begin
                        lcnt_next = lcnt - 2'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    if (load_hit) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_next = LOAD_STALL;
                            lcnt_next  = LCNT_INIT;
                        end
                    end
                end
            endcase
            if (mult_hit) begin
                stall = 1'b1;
            end
        end
    end

    // Multiplier busy down-counter; independent of the FSM and of branches
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mcnt <= 4'd0;
        end else if (hz.MultStart) begin
            mcnt <= MCNT_INIT;
        end else if (mcnt != 4'd0) begin
            mcnt <= mcnt - 4'd1;
        end
    end

    // Outputs forced low while reset is held, regardless of input activity
    assign hz.Stall      = Reset && stall;
    assign hz.IDEXBubble = Reset && stall;
    assign hz.IFIDFlush  = Reset && flush;
    assign hz.MultBusy   = Reset && mult_busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count;

    // Saturating count of stalled cycles
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stall_count <= 32'd0;
        end else if (hz.Stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign hz.StallCount = stall_count;
`endif

endmodule
